// File: rtl/carry_save_adder.sv
`default_nettype none
// ============================================================================
//  Module      : carry_save_adder
//  Description : Four-operand unsigned adder, S = W + X + Y + Z.
//                The operands pass through two carry-save levels built from
//                full-adder cells. A 6-bit ripple-carry adder then resolves
//                the result, and the result is registered once.
//
//  Ports       : clk              system clock, rising edge
//                reset_n          asynchronous active-low reset
//                w0..w3           operand W, w0 = LSB
//                x0..x3           operand X, x0 = LSB
//                y0..y3           operand Y, y0 = LSB
//                z0..z3           operand Z, z0 = LSB
//                s0..s5           registered sum, s0 = LSB (range 0..60)
//
//  Revision    : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  Single-bit full-adder cell shared by the CSA levels and the ripple stage.
// ----------------------------------------------------------------------------
module carry_save_adder_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module carry_save_adder (
    input  logic clk,
    input  logic reset_n,
    input  logic w0,
    input  logic w1,
    input  logic w2,
    input  logic w3,
    input  logic x0,
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic y0,
    input  logic y1,
    input  logic y2,
    input  logic y3,
    input  logic z0,
    input  logic z1,
    input  logic z2,
    input  logic z3,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic s4,
    output logic s5
);

    localparam int OP_W  = 4;
    localparam int CSA_W = 5;
    localparam int SUM_W = 6;

    logic [OP_W-1:0]  w_w;
    logic [OP_W-1:0]  w_x;
    logic [OP_W-1:0]  w_y;
    logic [OP_W-1:0]  w_z;

    // Level-1 outputs. The carry vector carries weight 2.
    logic [OP_W-1:0]  w_s1;
    logic [OP_W-1:0]  w_c1;

    // Level-2 inputs, aligned to a common 5-bit span, and the level-2 outputs.
    logic [CSA_W-1:0] w_l2_a;
    logic [CSA_W-1:0] w_l2_b;
    logic [CSA_W-1:0] w_l2_c;
    logic [CSA_W-1:0] w_s2;
    logic [CSA_W-1:0] w_c2;

    // Ripple stage operands, the carry chain and the result.
    logic [SUM_W-1:0] w_rc_a;
    logic [SUM_W-1:0] w_rc_b;
    logic [SUM_W-1:0] w_rc_carry;
    logic [SUM_W-1:0] w_sum;

    logic [SUM_W-1:0] r_sum;

    assign w_w = {w3, w2, w1, w0};
    assign w_x = {x3, x2, x1, x0};
    assign w_y = {y3, y2, y1, y0};
    assign w_z = {z3, z2, z1, z0};

    // ------------------------------------------------------------------
    // CSA level 1: W + X + Y -> S1 + 2*C1
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < OP_W; i++) begin : g_csa1
            carry_save_adder_fa u_fa (
                .a    (w_w[i]),
                .b    (w_x[i]),
                .cin  (w_y[i]),
                .sum  (w_s1[i]),
                .cout (w_c1[i])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // CSA level 2: S1 + {C1,0} + Z -> S2 + 2*C2, over a 5-bit span.
    // Top bit: only C1[3] is non-zero, so C2[4] is always 0.
    // ------------------------------------------------------------------
    assign w_l2_a = {1'b0, w_s1};
    assign w_l2_b = {w_c1, 1'b0};
    assign w_l2_c = {1'b0, w_z};

    generate
        for (genvar i = 0; i < CSA_W; i++) begin : g_csa2
            carry_save_adder_fa u_fa (
                .a    (w_l2_a[i]),
                .b    (w_l2_b[i]),
                .cin  (w_l2_c[i]),
                .sum  (w_s2[i]),
                .cout (w_c2[i])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Final 6-bit ripple-carry adder: S2 + {C2,0}.
    // The maximum sum is 60, so the carry out of bit 5 is always 0.
    // Bit 5 therefore needs only the sum half of a full adder.
    // ------------------------------------------------------------------
    assign w_rc_a        = {1'b0, w_s2};
    assign w_rc_b        = {w_c2, 1'b0};
    assign w_rc_carry[0] = 1'b0;

    generate
        for (genvar i = 0; i < SUM_W - 1; i++) begin : g_ripple
            carry_save_adder_fa u_fa (
                .a    (w_rc_a[i]),
                .b    (w_rc_b[i]),
                .cin  (w_rc_carry[i]),
                .sum  (w_sum[i]),
                .cout (w_rc_carry[i+1])
            );
        end
    endgenerate

    assign w_sum[SUM_W-1] = w_rc_a[SUM_W-1] ^ w_rc_b[SUM_W-1] ^ w_rc_carry[SUM_W-1];

    // ------------------------------------------------------------------
    // Output register: captures a new sum on every edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sum;
        end
    end

    assign s0 = r_sum[0];
    assign s1 = r_sum[1];
    assign s2 = r_sum[2];
    assign s3 = r_sum[3];
    assign s4 = r_sum[4];
    assign s5 = r_sum[5];

endmodule
`default_nettype wire

// File: tb/tb_carry_save_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_carry_save_adder
//  Description : Self-checking bench for carry_save_adder. A plain
//                arithmetic reference model is compared on every falling
//                edge. Directed vectors with literal expected values pin
//                the model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_carry_save_adder;

    logic       clk;
    logic       reset_n;
    logic [3:0] wv;
    logic [3:0] xv;
    logic [3:0] yv;
    logic [3:0] zv;
    logic [5:0] s_vec;

    int compared;
    int mismatched;
    bit cmp_en;

    logic [5:0] model_q;

    carry_save_adder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .w0 (wv[0]), .w1 (wv[1]), .w2 (wv[2]), .w3 (wv[3]),
        .x0 (xv[0]), .x1 (xv[1]), .x2 (xv[2]), .x3 (xv[3]),
        .y0 (yv[0]), .y1 (yv[1]), .y2 (yv[2]), .y3 (yv[3]),
        .z0 (zv[0]), .z1 (zv[1]), .z2 (zv[2]), .z3 (zv[3]),
        .s0 (s_vec[0]), .s1 (s_vec[1]), .s2 (s_vec[2]),
        .s3 (s_vec[3]), .s4 (s_vec[4]), .s5 (s_vec[5])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the sum of the operands at the last edge, zero under reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_q <= 6'd0;
        else          model_q <= 6'(wv) + 6'(xv) + 6'(yv) + 6'(zv);
    end

    // Continuous compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            compared++;
            if (s_vec !== model_q) begin
                mismatched++;
                $display("FAIL model_cmp t=%0t w=%0d x=%0d y=%0d z=%0d got=%0d exp=%0d",
                         $time, wv, xv, yv, zv, s_vec, model_q);
            end
        end
    end

    task automatic check(input string name, input logic [5:0] exp);
        compared++;
        if (s_vec !== exp) begin
            mismatched++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, s_vec, exp);
        end
    endtask

    // Drive operands just after an edge, then sample 1 ns after the next edge.
    task automatic apply(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        wv = a; xv = b; yv = c; zv = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        cmp_en     = 1'b0;
        reset_n    = 1'b1;
        wv = 4'd15; xv = 4'd15; yv = 4'd15; zv = 4'd15;
        #1 reset_n = 1'b0;
        #1 cmp_en  = 1'b1;

        // The reset holds the output at 0 while operands are at maximum.
        check("reset_immediate", 6'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("reset_hold", 6'd0);
        end
        reset_n = 1'b1;
        #1 check("reset_release_no_edge", 6'd0);
        @(posedge clk); #1;
        check("after_release_60", 6'd60);

        // Carry-chain corners.
        apply(4'd15, 4'd15, 4'd15, 4'd15); check("all_15", 6'd60);
        apply(4'd1,  4'd1,  4'd1,  4'd1);  check("all_1",  6'd4);
        apply(4'd8,  4'd8,  4'd8,  4'd8);  check("all_8",  6'd32);

        // Single-operand walk on every port bit.
        for (int op = 0; op < 4; op++) begin
            for (int b = 0; b < 4; b++) begin
                logic [3:0] v;
                v = 4'(1 << b);
                case (op)
                    0: apply(v, 4'd0, 4'd0, 4'd0);
                    1: apply(4'd0, v, 4'd0, 4'd0);
                    2: apply(4'd0, 4'd0, v, 4'd0);
                    default: apply(4'd0, 4'd0, 4'd0, v);
                endcase
                check("walk", 6'(1 << b));
            end
        end

        // Latency: an operand change after an edge is invisible until the next edge.
        apply(4'd0, 4'd0, 4'd0, 4'd0);
        check("latency_zero", 6'd0);
        wv = 4'd3; xv = 4'd5; yv = 4'd7; zv = 4'd9;
        #2 check("latency_hold", 6'd0);
        @(posedge clk); #1;
        check("latency_24", 6'd24);

        // An async reset between edges clears the output at once. No replay
        // follows, and the next edge restores the sum.
        #2 reset_n = 1'b0;
        #1 check("async_reset_clear", 6'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("after_async_24", 6'd24);

        // Exhaustive sweep with the continuous model compare.
        for (int i = 0; i < 65536; i++) begin
            apply(4'(i), 4'(i >> 4), 4'(i >> 8), 4'(i >> 12));
        end
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
